// File: rtl/iq_bus_xcvr.sv
// Half-duplex I/Q sample-bus transceiver: TX packing, RX beat deserialiser, guarded turnaround FSM.
// Optional macro IQBUS_SYNC_EN: RX hunts for SYNC_WORD before packing on every entry to RX.
module iq_bus_xcvr #(
   parameter int                  IQ_W      = 4,
   parameter int                  RX_BEATS  = 2,
   parameter int                  TURN_CYC  = 2,
   parameter logic [2*IQ_W-1:0]   SYNC_WORD = 8'hA5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode_sel,
   input  logic signed [IQ_W-1:0]       tx_i,
   input  logic signed [IQ_W-1:0]       tx_q,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   input  logic [2*IQ_W-1:0]            bus_in,
   output logic [2*IQ_W-1:0]            bus_out,
   output logic                         bus_oe,
   output logic [RX_BEATS*2*IQ_W-1:0]   rx_word,
   output logic                         rx_valid,
   output logic                         busy
);

   localparam int BUS_W  = 2*IQ_W;
   localparam int WORD_W = RX_BEATS*BUS_W;
   localparam int CNT_W  = (RX_BEATS > 1) ? $clog2(RX_BEATS) : 1;

`ifdef IQBUS_SYNC_EN
   localparam logic HUNT_ON_ENTRY = 1'b1;
`else
   localparam logic HUNT_ON_ENTRY = 1'b0;
`endif

   typedef enum logic [1:0] {RX_IDLE, TURN_TX, TX, TURN_RX} state_t;

   state_t             state, state_next;
   logic [3:0]         turn_cnt;
   logic               turn_done;
   logic               in_turn;

   logic [BUS_W-1:0]   in_q;
   logic               prev_rx;
   logic [CNT_W-1:0]   beat_cnt;
   logic [WORD_W-1:0]  acc;
   logic [WORD_W-1:0]  word_next;
   logic               hunting;
   logic               pack_cycle;
   logic               last_beat;
   logic               sync_hit;
   int                 beat_slot;

   assign in_turn   = (state == TURN_TX) || (state == TURN_RX);
   assign turn_done = (turn_cnt == 4'(TURN_CYC-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_next;
   end

   // Turnaround states always run their full guard interval, whatever mode_sel does meanwhile.
   always_comb begin
      state_next = state;
      bus_oe     = 1'b0;
      tx_ready   = 1'b0;
      busy       = 1'b0;
      case (state)
         RX_IDLE: if (!mode_sel) state_next = TURN_TX;
         TURN_TX: begin
            busy = 1'b1;
            if (turn_done) state_next = TX;
         end
         TX: begin
            bus_oe   = 1'b1;
            tx_ready = 1'b1;
            if (mode_sel) state_next = TURN_RX;
         end
         TURN_RX: begin
            busy = 1'b1;
            if (turn_done) state_next = RX_IDLE;
         end
         default: state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     turn_cnt <= '0;
      else if (in_turn && !turn_done) turn_cnt <= turn_cnt + 4'd1;
      else                            turn_cnt <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     bus_out <= '0;
      else if (tx_ready && tx_valid)  bus_out <= {tx_i, tx_q};
      else                            bus_out <= '0;
   end

   // The first RX cycle's in_q still holds a beat sampled during turnaround, so it is skipped.
   assign pack_cycle = (state == RX_IDLE) && prev_rx;
   assign last_beat  = (beat_cnt == CNT_W'(RX_BEATS-1));
   assign sync_hit   = (in_q == SYNC_WORD);

   always_comb begin
      word_next = acc;
      beat_slot = RX_BEATS - 1 - int'(beat_cnt);
      word_next[beat_slot*BUS_W +: BUS_W] = in_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q     <= '0;
         prev_rx  <= 1'b0;
         beat_cnt <= '0;
         acc      <= '0;
         rx_word  <= '0;
         rx_valid <= 1'b0;
         hunting  <= HUNT_ON_ENTRY;
      end else begin
         in_q     <= bus_in;
         prev_rx  <= (state == RX_IDLE);
         rx_valid <= 1'b0;
         if (state != RX_IDLE) begin
            beat_cnt <= '0;
            acc      <= '0;
            hunting  <= HUNT_ON_ENTRY;
         end else if (pack_cycle && hunting) begin
            if (sync_hit) hunting <= 1'b0;
         end else if (pack_cycle) begin
            if (last_beat) begin
               rx_word  <= word_next;
               rx_valid <= 1'b1;
               beat_cnt <= '0;
               acc      <= '0;
            end else begin
               acc      <= word_next;
               beat_cnt <= beat_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_iq_bus_xcvr.sv
// Directed, table-driven bench for iq_bus_xcvr in its default build (IQ_W=4, RX_BEATS=2, TURN_CYC=2).
module tb_iq_bus_xcvr;

   logic               clk;
   logic               rst_n;
   logic               mode_sel;
   logic signed [3:0]  tx_i;
   logic signed [3:0]  tx_q;
   logic               tx_valid;
   logic               tx_ready;
   logic [7:0]         bus_in;
   logic [7:0]         bus_out;
   logic               bus_oe;
   logic [15:0]        rx_word;
   logic               rx_valid;
   logic               busy;

   int passCount  = 0;
   int checkCount = 0;

   iq_bus_xcvr #(.IQ_W(4), .RX_BEATS(2), .TURN_CYC(2), .SYNC_WORD(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode_sel (mode_sel),
      .tx_i     (tx_i),
      .tx_q     (tx_q),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .bus_in   (bus_in),
      .bus_out  (bus_out),
      .bus_oe   (bus_oe),
      .rx_word  (rx_word),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        mode_sel;
      logic        tx_valid;
      logic [3:0]  tx_i;
      logic [3:0]  tx_q;
      logic [7:0]  bus_in;
      logic        exp_oe;
      logic        exp_busy;
      logic        exp_rdy;
      logic [7:0]  exp_out;
      logic        exp_rv;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [24];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      mode_sel = v.mode_sel;
      tx_valid = v.tx_valid;
      tx_i     = v.tx_i;
      tx_q     = v.tx_q;
      bus_in   = v.bus_in;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      checkOutput($sformatf("v%0d.bus_oe", idx),   16'(bus_oe),   16'(v.exp_oe));
      checkOutput($sformatf("v%0d.busy", idx),     16'(busy),     16'(v.exp_busy));
      checkOutput($sformatf("v%0d.tx_ready", idx), 16'(tx_ready), 16'(v.exp_rdy));
      checkOutput($sformatf("v%0d.bus_out", idx),  16'(bus_out),  16'(v.exp_out));
      checkOutput($sformatf("v%0d.rx_valid", idx), 16'(rx_valid), 16'(v.exp_rv));
      checkOutput($sformatf("v%0d.rx_word", idx),  rx_word,       v.exp_word);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Fields: mode, txv, i, q, bus_in | oe, busy, rdy, bus_out, rv, rx_word
      vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000};
      vecs[3]  = '{1'b0, 1'b1, 4'hD, 4'h3, 8'h00, 1'b1, 1'b0, 1'b1, 8'hD3, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 1'b1, 4'h7, 4'h8, 8'h00, 1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000};
      vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h56, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234};
      vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h78, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1234};
      vecs[13] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h5678};
      vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h5678};
      vecs[17] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[18] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[19] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[20] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'hAB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[21] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'hCD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h5678};
      vecs[22] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hABCD};
      vecs[23] = '{1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'hABCD};

      // Hold reset with mode_sel = 0; the FSM must stay parked in RX.
      rst_n    = 1'b0;
      mode_sel = 1'b0;
      tx_valid = 1'b0;
      tx_i     = '0;
      tx_q     = '0;
      bus_in   = '0;
      tick();
      tick();
      checkOutput("reset.bus_oe",   16'(bus_oe),   16'h0);
      checkOutput("reset.busy",     16'(busy),     16'h0);
      checkOutput("reset.tx_ready", 16'(tx_ready), 16'h0);
      checkOutput("reset.bus_out",  16'(bus_out),  16'h00);
      checkOutput("reset.rx_valid", 16'(rx_valid), 16'h0);
      checkOutput("reset.rx_word",  rx_word,       16'h0000);
      rst_n = 1'b1;

      // Reset release, TX, turnaround with revert, RX packing and mid-word abort.
      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkVector(i, vecs[i]);
      end

      // Async reset while driving in TX: the pads release without waiting for a clock.
      mode_sel = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("seqA.in_tx_oe", 16'(bus_oe), 16'h1);
      tx_valid = 1'b1;
      tx_i     = 4'sh5;
      tx_q     = 4'shA;
      tick();
      checkOutput("seqA.bus_out", 16'(bus_out), 16'h5A);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("seqA.async_oe",      16'(bus_oe),   16'h0);
      checkOutput("seqA.async_bus_out", 16'(bus_out),  16'h00);
      checkOutput("seqA.async_tx_rdy",  16'(tx_ready), 16'h0);
      checkOutput("seqA.async_rx_word", rx_word,       16'h0000);

      // Async reset in the middle of an RX word: the partial beat must not survive.
      mode_sel = 1'b1;
      tx_valid = 1'b0;
      tick();
      rst_n  = 1'b1;
      bus_in = 8'h11;
      tick();
      bus_in = 8'h22;
      tick();
      checkOutput("seqB.partial_rv", 16'(rx_valid), 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("seqB.async_rv",   16'(rx_valid), 16'h0);
      checkOutput("seqB.async_word", rx_word,       16'h0000);
      tick();
      rst_n  = 1'b1;
      bus_in = 8'h33;
      tick();
      bus_in = 8'h44;
      tick();
      checkOutput("seqB.first_beat_rv", 16'(rx_valid), 16'h0);
      bus_in = 8'h00;
      tick();
      checkOutput("seqB.word_rv", 16'(rx_valid), 16'h1);
      checkOutput("seqB.word",    rx_word,       16'h3344);
      tick();
      checkOutput("seqB.hold_rv",   16'(rx_valid), 16'h0);
      checkOutput("seqB.hold_word", rx_word,       16'h3344);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/iq_bus_xcvr.md
Name: iq_bus_xcvr

Overview:
Parametrised half-duplex transceiver front end between the on-chip modem datapath and the off-chip sample bus. In TX mode it packs signed I/Q samples onto the bus. In RX mode it deserialises multiple bus beats into one wide word for the demodulator. Mode changes go through a bus-turnaround state machine with a guard interval, so the chip never drives the pads while the far end may still be driving them.

Parameters:
IQ_W, 4, width of each signed I and Q component; the bus width BUS_W = 2*IQ_W is derived, not a parameter.
RX_BEATS, 2, bus beats packed into one RX word; legal range 1..8.
TURN_CYC, 2, guard cycles with the bus undriven on every mode change; legal range 1..15.
SYNC_WORD, 8'hA5, RX frame-sync beat; used only when IQBUS_SYNC_EN is defined; width BUS_W.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
mode_sel  in  1  0 = TX (modulate), 1 = RX (demodulate).
tx_i  in  IQ_W  signed I sample.
tx_q  in  IQ_W  signed Q sample.
tx_valid  in  1  TX sample valid.
tx_ready  out  1  TX sample accepted on this edge when tx_valid is also high.
bus_in  in  BUS_W  pad input path.
bus_out  out  BUS_W  pad output path.
bus_oe  out  1  pad output enable; 1 = chip drives the bus.
rx_word  out  RX_BEATS*BUS_W  packed RX word; first beat received occupies the MSBs.
rx_valid  out  1  one-cycle strobe marking rx_word as new.
busy  out  1  high in either turnaround state.

Behaviour:
- Reset values: state = RX_IDLE, bus_oe = 0, bus_out = 0, rx_word = 0, rx_valid = 0, tx_ready = 0, busy = 0, beat counter = 0.
- Reset is asynchronous assert and synchronous release. Asserting reset mid-operation drops bus_oe to 0 immediately and discards any partial RX word.
- States:
  - RX: bus_oe = 0; packing is active.
  - TURN_TX: bus_oe = 0; busy = 1; guard count runs.
  - TX: bus_oe = 1; tx_ready = 1.
  - TURN_RX: bus_oe = 0; busy = 1; guard count runs.
- Transitions:
  - RX goes to TURN_TX when mode_sel = 0.
  - TURN_TX goes to TX after exactly TURN_CYC cycles in TURN_TX.
  - TX goes to TURN_RX when mode_sel = 1; bus_oe falls on that same edge.
  - TURN_RX goes to RX after exactly TURN_CYC cycles in TURN_RX.
  - If mode_sel reverts during a TURN state, the turnaround still completes, and the opposite turnaround then starts from the new state. A TURN state is never aborted.
- TX datapath:
  - tx_ready is a combinational decode of state == TX.
  - On an edge with tx_valid & tx_ready, bus_out <= {tx_i, tx_q}, I in the MSBs. Latency is 1 cycle.
  - In TX with tx_valid = 0, bus_out <= 0 (mid-scale idle).
  - Outside TX, bus_out holds 0.
- RX datapath:
  - bus_in passes through one input register (in_q) every cycle, in all states.
  - Packing consumes in_q only on cycles where the state is RX and the state was also RX on the previous cycle, so the first beat after turnaround is in_q's first clean sample.
  - The beat counter runs 0..RX_BEATS-1. The beat at count k is stored at slice (RX_BEATS-1-k).
  - When count RX_BEATS-1 is stored, rx_word updates and rx_valid pulses high for 1 cycle. The counter wraps to 0.
  - Latency: rx_valid rises 2 edges after the last beat is present on bus_in.
  - Back-to-back words are produced with no gap cycles.
  - rx_word holds its value between strobes.
  - On leaving RX, the beat counter clears to 0, the partial word is discarded, and rx_word holds its last complete value.
- Arithmetic: none. Samples pass through bit-exact; no sign extension or saturation.

Optional Feature:
IQBUS_SYNC_EN:
- Defined: on entering RX, the packer is in a HUNT sub-state. Beats are discarded until in_q == SYNC_WORD. The sync beat itself is discarded, and packing starts with the next beat. Alignment holds until RX is left, and re-entering RX re-hunts.
- Not defined: no HUNT sub-state; packing starts with the first clean beat, and SYNC_WORD is unused.

Test Plan:
- Reset: hold rst_n low with mode_sel = 0 -> bus_oe = 0, bus_out = 0, rx_valid = 0, state RX. After release: busy = 1 for 2 cycles, then bus_oe = 1 and tx_ready = 1.
- TX: in TX, tx_valid = 1, tx_i = 4'sb1101, tx_q = 4'sb0011 -> bus_out = 8'hD3 one edge later. Drop tx_valid -> bus_out = 8'h00 the next edge.
- Turnaround: in TX, set mode_sel = 1 -> bus_oe = 0 on the same edge, busy = 1 for exactly TURN_CYC = 2 cycles, rx_valid stays 0 until the first complete word.
- RX packing: RX_BEATS = 2, drive bus_in 12, 34, 56, 78 on consecutive cycles after entry -> rx_word = 16'h1234 (1-cycle rx_valid), then 16'h5678 with no gap.
- Mid-word abort: drive one beat, then mode_sel = 0 -> no rx_valid; rx_word keeps its previous value. On re-entry to RX, the next two beats AB, CD give rx_word = 16'hABCD.
- Sync (IQBUS_SYNC_EN, SYNC_WORD = A5): drive 11, A5, 22, 33 -> rx_word = 16'h2233; the 11 and A5 beats never appear in rx_word. Mid-frame async reset -> bus_oe = 0 immediately and HUNT resumes.
